// File: rtl/arith_order_seq.sv
// rtl/arith_order_seq.sv - order/answer initiator between the program unit and the arithmetic controller
module arith_order_seq #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMER_WIDTH    = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_from_pu,
    input  logic [2:0] op_code_from_pu,
    input  logic       au_answer_from_au,
    input  logic       reg_b_sign_from_au,
    output logic       order_add_to_au,
    output logic       order_sub_to_au,
    output logic       order_mul_to_au,
    output logic       order_div_to_au,
    output logic       order_and_to_au,
    output logic       clear_a_to_au,
    output logic       busy_to_pu,
    output logic       done_to_pu,
    output logic       result_sign_to_pu,
    output logic       timeout_to_pu,
    output logic       div_overflow_to_pu,
    output logic       illegal_op_to_pu
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_WAIT  = 5'b00100,
        S_DONE  = 5'b01000,
        S_ABORT = 5'b10000
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;

    // Last WAIT cycle index; an answer arriving in this cycle still wins over the abort
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [2:0]             op_reg;
    logic [TIMER_WIDTH-1:0] timer;

    // Sequencer with registered outputs: each pulse is set on the edge entering its state
    // and cleared by the default on the following edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state              <= S_IDLE;
            op_reg             <= 3'd0;
            timer              <= '0;
            order_add_to_au    <= 1'b0;
            order_sub_to_au    <= 1'b0;
            order_mul_to_au    <= 1'b0;
            order_div_to_au    <= 1'b0;
            order_and_to_au    <= 1'b0;
            clear_a_to_au      <= 1'b0;
            busy_to_pu         <= 1'b0;
            done_to_pu         <= 1'b0;
            result_sign_to_pu  <= 1'b0;
            timeout_to_pu      <= 1'b0;
            div_overflow_to_pu <= 1'b0;
            illegal_op_to_pu   <= 1'b0;
        end else begin
            order_add_to_au    <= 1'b0;
            order_sub_to_au    <= 1'b0;
            order_mul_to_au    <= 1'b0;
            order_div_to_au    <= 1'b0;
            order_and_to_au    <= 1'b0;
            clear_a_to_au      <= 1'b0;
            done_to_pu         <= 1'b0;
            timeout_to_pu      <= 1'b0;
            div_overflow_to_pu <= 1'b0;
            illegal_op_to_pu   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_from_pu) begin
                        if (op_code_from_pu <= OP_AND) begin
                            op_reg          <= op_code_from_pu;
                            state           <= S_ISSUE;
                            busy_to_pu      <= 1'b1;
                            order_add_to_au <= (op_code_from_pu == OP_ADD);
                            order_sub_to_au <= (op_code_from_pu == OP_SUB);
                            order_mul_to_au <= (op_code_from_pu == OP_MUL);
                            order_div_to_au <= (op_code_from_pu == OP_DIV);
                            order_and_to_au <= (op_code_from_pu == OP_AND);
                        end else begin
                            illegal_op_to_pu <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    // Answers seen here belong to an older operation and are dropped
                    timer <= '0;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (au_answer_from_au) begin
                        result_sign_to_pu <= reg_b_sign_from_au;
                        done_to_pu        <= 1'b1;
                        state             <= S_DONE;
                    end else if (timer == TIMER_LAST) begin
                        // A silent div stall means the controller gave up on quotient overflow
                        clear_a_to_au      <= 1'b1;
                        div_overflow_to_pu <= (op_reg == OP_DIV);
                        timeout_to_pu      <= (op_reg != OP_DIV);
                        state              <= S_ABORT;
                    end
                end

                S_DONE: begin
                    busy_to_pu <= 1'b0;
                    state      <= S_IDLE;
                end

                S_ABORT: begin
                    busy_to_pu <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    busy_to_pu <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_order_seq.sv
// tb/tb_arith_order_seq.sv - randomized and directed bench with a transaction-timing reference model
module tb_arith_order_seq;

    localparam int TO = 16;

    logic       clk;
    logic       resetn;
    logic       start_from_pu;
    logic [2:0] op_code_from_pu;
    logic       au_answer_from_au;
    logic       reg_b_sign_from_au;
    logic       order_add_to_au, order_sub_to_au, order_mul_to_au, order_div_to_au, order_and_to_au;
    logic       clear_a_to_au, busy_to_pu, done_to_pu, result_sign_to_pu;
    logic       timeout_to_pu, div_overflow_to_pu, illegal_op_to_pu;

    arith_order_seq #(.TIMEOUT_CYCLES(TO), .TIMER_WIDTH(8)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .start_from_pu      (start_from_pu),
        .op_code_from_pu    (op_code_from_pu),
        .au_answer_from_au  (au_answer_from_au),
        .reg_b_sign_from_au (reg_b_sign_from_au),
        .order_add_to_au    (order_add_to_au),
        .order_sub_to_au    (order_sub_to_au),
        .order_mul_to_au    (order_mul_to_au),
        .order_div_to_au    (order_div_to_au),
        .order_and_to_au    (order_and_to_au),
        .clear_a_to_au      (clear_a_to_au),
        .busy_to_pu         (busy_to_pu),
        .done_to_pu         (done_to_pu),
        .result_sign_to_pu  (result_sign_to_pu),
        .timeout_to_pu      (timeout_to_pu),
        .div_overflow_to_pu (div_overflow_to_pu),
        .illegal_op_to_pu   (illegal_op_to_pu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one operation described by its accept cycle and answer cycle
    int         cyc = 0;
    int         p;
    bit         active = 0;
    bit         ans_seen = 0;
    bit         ill = 0;
    bit         msign = 0;
    int         t_s = 0;
    int         t_ans = 0;
    int         m_code = 0;
    logic [11:0] exp_vec = '0;

    function automatic int end_c();
        return ans_seen ? t_ans + 1 : t_s + 2 + TO;
    endfunction

    // Per-cycle expectations for the cycle just started, from the inputs of the cycle just ended
    always @(posedge clk or negedge resetn) begin
        if (clk) cyc = cyc + 1;
        if (!resetn) begin
            active   = 0;
            ans_seen = 0;
            msign    = 0;
            ill      = 0;
            exp_vec  = '0;
        end else begin
            p = cyc - 1;
            if (active && !ans_seen && au_answer_from_au && p >= t_s + 2 && p <= t_s + 1 + TO) begin
                ans_seen = 1;
                t_ans    = p;
                msign    = reg_b_sign_from_au;
            end
            if (active && p > end_c()) active = 0;
            ill = 0;
            if (!active && start_from_pu) begin
                if (op_code_from_pu <= 3'd4) begin
                    active   = 1;
                    t_s      = p;
                    m_code   = int'(op_code_from_pu);
                    ans_seen = 0;
                end else begin
                    ill = 1;
                end
            end
            exp_vec = '0;
            if (active && cyc == t_s + 1) exp_vec[11 - m_code] = 1'b1;
            if (active && !ans_seen && cyc == t_s + 2 + TO) begin
                exp_vec[6] = 1'b1;
                if (m_code == 3) exp_vec[1] = 1'b1;
                else             exp_vec[2] = 1'b1;
            end
            exp_vec[5] = active && cyc >= t_s + 1 && cyc <= end_c();
            exp_vec[4] = active && ans_seen && cyc == t_ans + 1;
            exp_vec[3] = msign;
            exp_vec[0] = ill;
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_ord = 0;
    int          n_dn = 0;
    bit          cmp_en = 0;
    logic [11:0] act;

    task automatic step();
        @(negedge clk);
        if (cmp_en) begin
            act = {order_add_to_au, order_sub_to_au, order_mul_to_au, order_div_to_au, order_and_to_au,
                   clear_a_to_au, busy_to_pu, done_to_pu, result_sign_to_pu,
                   timeout_to_pu, div_overflow_to_pu, illegal_op_to_pu};
            n_cmp++;
            if (act !== exp_vec) begin
                n_bad++;
                $display("FAIL cycle_compare cyc=%0d got=%b expected=%b", cyc, act, exp_vec);
            end
            n_ord += int'(order_add_to_au) + int'(order_sub_to_au) + int'(order_mul_to_au)
                   + int'(order_div_to_au) + int'(order_and_to_au);
            n_dn  += int'(done_to_pu);
        end
        #1;
    endtask

    task automatic chk(input string nm, input int a, input int e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, a, e);
        end
    endtask

    task automatic idle(input int n);
        start_from_pu     = 0;
        au_answer_from_au = 0;
        repeat (n) step();
    endtask

    // Add with answer at T+3 and B sign 1
    task automatic add_scenario();
        step(); start_from_pu = 1; op_code_from_pu = 3'd0;
        step(); start_from_pu = 0;
        chk("add_order_t1", int'(order_add_to_au), 1);
        chk("add_busy_t1", int'(busy_to_pu), 1);
        step();
        chk("add_order_t2", int'(order_add_to_au), 0);
        step(); au_answer_from_au = 1; reg_b_sign_from_au = 1;
        step(); au_answer_from_au = 0; reg_b_sign_from_au = 0;
        chk("add_done_t4", int'(done_to_pu), 1);
        chk("add_sign_t4", int'(result_sign_to_pu), 1);
        chk("add_busy_t4", int'(busy_to_pu), 1);
        step();
        chk("add_busy_t5", int'(busy_to_pu), 0);
        chk("add_done_t5", int'(done_to_pu), 0);
    endtask

    int t0;
    int d;
    int o0;
    int d0;

    initial begin
        resetn = 1; start_from_pu = 0; op_code_from_pu = 0;
        au_answer_from_au = 0; reg_b_sign_from_au = 0;
        #3 resetn = 0;
        step(); step();
        cmp_en = 1;
        step();
        chk("reset_busy", int'(busy_to_pu), 0);
        chk("reset_sign", int'(result_sign_to_pu), 0);
        resetn = 1;
        idle(2);

        add_scenario();
        idle(2);

        // Every code: legal ones give one matching order, illegal ones only a flag
        for (int c = 0; c < 8; c++) begin
            step(); start_from_pu = 1; op_code_from_pu = 3'(c);
            step(); start_from_pu = 0;
            if (c <= 4) begin
                chk("code_orders", int'({order_add_to_au, order_sub_to_au, order_mul_to_au,
                                         order_div_to_au, order_and_to_au}), 16 >> c);
                step(); au_answer_from_au = 1;
                step(); au_answer_from_au = 0;
                chk("code_done", int'(done_to_pu), 1);
                step();
            end else begin
                chk("illegal_flag", int'(illegal_op_to_pu), 1);
                chk("illegal_busy", int'(busy_to_pu), 0);
            end
        end
        idle(2);

        // Div and mul without answer
        for (int k = 0; k < 2; k++) begin
            step(); start_from_pu = 1; op_code_from_pu = (k == 0) ? 3'd3 : 3'd2; t0 = cyc;
            step(); start_from_pu = 0;
            d = -1;
            for (int i = 0; i < 40; i++) begin
                if (clear_a_to_au) begin d = cyc - t0; break; end
                step();
            end
            chk("abort_latency", d, 18);
            chk("abort_div_ovf", int'(div_overflow_to_pu), (k == 0) ? 1 : 0);
            chk("abort_timeout", int'(timeout_to_pu), (k == 0) ? 0 : 1);
            idle(2);
        end

        // Answer in the last WAIT cycle, then one cycle too late
        for (int k = 0; k < 2; k++) begin
            step(); start_from_pu = 1; op_code_from_pu = 3'd1; t0 = cyc;
            step(); start_from_pu = 0;
            for (int i = 0; i < 40 && cyc < t0 + 17 + k; i++) step();
            au_answer_from_au = 1;
            step(); au_answer_from_au = 0;
            if (k == 0) begin
                chk("last_wait_done", int'(done_to_pu), 1);
                chk("last_wait_clear", int'(clear_a_to_au), 0);
            end else begin
                chk("late_done", int'(done_to_pu), 0);
                chk("late_busy", int'(busy_to_pu), 0);
            end
            idle(2);
        end

        // Starts during WAIT/DONE and an answer during ISSUE are all dropped
        o0 = n_ord; d0 = n_dn;
        step(); start_from_pu = 1; op_code_from_pu = 3'd1;
        step(); au_answer_from_au = 1; op_code_from_pu = 3'd2;
        step(); au_answer_from_au = 0; op_code_from_pu = 3'd0;
        step(); start_from_pu = 0; au_answer_from_au = 1;
        step(); au_answer_from_au = 0; start_from_pu = 1;
        step(); start_from_pu = 0;
        idle(3);
        chk("ignored_orders", n_ord - o0, 1);
        chk("ignored_dones", n_dn - d0, 1);

        // Asynchronous reset mid-WAIT
        step(); start_from_pu = 1; op_code_from_pu = 3'd2;
        step(); start_from_pu = 0;
        step(); step();
        #2 resetn = 0;
        #1 chk("async_reset_busy", int'(busy_to_pu), 0);
        step(); resetn = 1;
        idle(1);
        add_scenario();
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            resetn             = 1;
            start_from_pu      = ($urandom_range(0, 3) == 0);
            op_code_from_pu    = 3'($urandom_range(0, 7));
            au_answer_from_au  = ($urandom_range(0, 9) == 0);
            reg_b_sign_from_au = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) #2 resetn = 0;
        end
        resetn = 1;
        idle(TO + 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
